regfile_wb_arbiter: RTL and testbench

- Shares the register file's two write ports (wra/wrb) among NUM_REQ writeback producers, such as ALU, MUL, LSU and branch units.
- Each producer hands off through a valid/ready handshake into a one-entry holding slot.
- Each cycle, up to two held entries are granted round-robin onto wra_*/wrb_*.
- Writes to the zero register are retired without consuming a port. The block sits between functional-unit writeback and regfile.

---
 rtl/regfile_wb_arbiter_pkg.sv | 20 ++
 rtl/regfile_wb_arbiter_if.sv | 32 +++
 rtl/regfile_wb_arbiter_rr_pick2.sv | 45 ++++
 rtl/regfile_wb_arbiter.sv | 98 +++++++++
 tb/tb_regfile_wb_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared regfile writeback definitions: data/index widths, the writeback
// request record and the number of regfile write ports.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ZERO_REG
`define ZERO_REG 0
`endif

package rf_pkg;
  localparam int NUM_WR_PORTS = 2;
  localparam int RF_IDX_W     = 5;
  localparam int RF_DATA_W    = `XLEN;

  typedef struct packed {
    logic                 valid;
    logic [RF_IDX_W-1:0]  idx;
    logic [RF_DATA_W-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback producer handshake plus the two regfile write ports.
interface regfile_wb_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = rf_pkg::RF_DATA_W,
  parameter int IDX_W   = rf_pkg::RF_IDX_W
);
  localparam int CNT_W = $clog2(NUM_REQ + 1);

  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0][IDX_W-1:0]  req_idx;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]             req_ready;
  logic                           wra_en;
  logic [IDX_W-1:0]               wra_idx;
  logic [DATA_W-1:0]              wra_data;
  logic                           wrb_en;
  logic [IDX_W-1:0]               wrb_idx;
  logic [DATA_W-1:0]              wrb_data;
  logic [CNT_W-1:0]               pending_cnt;

  modport master (
    output req_valid, req_idx, req_data,
    input  req_ready, wra_en, wra_idx, wra_data,
    input  wrb_en, wrb_idx, wrb_data, pending_cnt
  );

  modport slave (
    input  req_valid, req_idx, req_data,
    output req_ready, wra_en, wra_idx, wra_data,
    output wrb_en, wrb_idx, wrb_data, pending_cnt
  );
endinterface

// File: rtl/regfile_wb_arbiter_rr_pick2.sv
// Circular two-hit picker: first eligible slot from rr_ptr goes to port A,
// the next eligible slot with a different register index goes to port B.
module rr_pick2 #(
  parameter  int NUM_REQ = 4,
  parameter  int IDX_W   = 5,
  localparam int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]            eligible,
  input  logic [PTR_W-1:0]              rr_ptr,
  input  logic [NUM_REQ-1:0][IDX_W-1:0] idx,
  output logic [NUM_REQ-1:0]            grant_a,
  output logic [NUM_REQ-1:0]            grant_b,
  output logic                          valid_a,
  output logic                          valid_b
);
  logic [PTR_W:0]   pos;
  logic [PTR_W-1:0] slot;
  logic [IDX_W-1:0] a_idx;

  always_comb begin
    grant_a = '0;
    grant_b = '0;
    valid_a = 1'b0;
    valid_b = 1'b0;
    a_idx   = '0;
    pos     = '0;
    slot    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      pos = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (pos >= (PTR_W+1)'(NUM_REQ))
        pos = pos - (PTR_W+1)'(NUM_REQ);
      slot = pos[PTR_W-1:0];
      if (eligible[slot]) begin
        if (!valid_a) begin
          grant_a[slot] = 1'b1;
          valid_a       = 1'b1;
          a_idx         = idx[slot];
        end else if (!valid_b && idx[slot] != a_idx) begin
          grant_b[slot] = 1'b1;
          valid_b       = 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the regfile's two write ports among NUM_REQ writeback producers,
// each buffered by a one-entry holding slot and granted round-robin.
module regfile_wb_arbiter
  import rf_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = RF_DATA_W,
  parameter int IDX_W   = RF_IDX_W
) (
  input logic           clk,
  input logic           reset,
  regfile_wb_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(NUM_REQ + 1);

  logic [NUM_REQ-1:0]             hold_valid;
  logic [NUM_REQ-1:0][IDX_W-1:0]  hold_idx;
  logic [NUM_REQ-1:0][DATA_W-1:0] hold_data;
  logic [PTR_W-1:0]               rr_ptr;

  logic [NUM_REQ-1:0] eligible, zero_hit, grant_a, grant_b, gnt_a, gnt_b, retire;
  logic               valid_a, valid_b, en_a, en_b;
  logic [PTR_W-1:0]   last_grant;
  logic [CNT_W-1:0]   cnt;

  always_comb begin
    eligible = '0;
    zero_hit = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      eligible[i] = hold_valid[i] && (hold_idx[i] != IDX_W'(`ZERO_REG));
      zero_hit[i] = hold_valid[i] && (hold_idx[i] == IDX_W'(`ZERO_REG));
    end
  end

  rr_pick2 #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .eligible (eligible),
    .rr_ptr   (rr_ptr),
    .idx      (hold_idx),
    .grant_a  (grant_a),
    .grant_b  (grant_b),
    .valid_a  (valid_a),
    .valid_b  (valid_b)
  );

  // Grants are suppressed during reset so entries discarded by reset never write.
  assign en_a   = valid_a && !reset;
  assign en_b   = valid_b && !reset;
  assign gnt_a  = {NUM_REQ{en_a}} & grant_a;
  assign gnt_b  = {NUM_REQ{en_b}} & grant_b;
  assign retire = gnt_a | gnt_b | zero_hit;

  always_comb begin
    bus.wra_en   = en_a;
    bus.wrb_en   = en_b;
    bus.wra_idx  = '0;
    bus.wra_data = '0;
    bus.wrb_idx  = '0;
    bus.wrb_data = '0;
    last_grant   = '0;
    cnt          = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_a[i]) begin
        bus.wra_idx  = hold_idx[i];
        bus.wra_data = hold_data[i];
        if (!en_b) last_grant = PTR_W'(i);
      end
      if (gnt_b[i]) begin
        bus.wrb_idx  = hold_idx[i];
        bus.wrb_data = hold_data[i];
        last_grant   = PTR_W'(i);
      end
      cnt = cnt + CNT_W'(hold_valid[i]);
    end
  end

  assign bus.pending_cnt = cnt;
  assign bus.req_ready   = reset ? '0 : ~hold_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_valid <= '0;
      rr_ptr     <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (bus.req_valid[i] && !hold_valid[i]) begin
          hold_valid[i] <= 1'b1;
          hold_idx[i]   <= bus.req_idx[i];
          hold_data[i]  <= bus.req_data[i];
        end else if (retire[i]) begin
          hold_valid[i] <= 1'b0;
        end
      end
      if (en_a)
        rr_ptr <= (last_grant == PTR_W'(NUM_REQ - 1)) ? '0 : last_grant + 1'b1;
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus a
// randomized run against a slot/queue-level reference model and regfile image.
module tb_regfile_wb_arbiter;
  import rf_pkg::*;

  localparam int N  = 4;
  localparam int IW = RF_IDX_W;
  localparam int DW = RF_DATA_W;
  localparam int CW = $clog2(N + 1);
  localparam int EW = 2 * (1 + IW + DW) + N + CW;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.NUM_REQ(N), .DATA_W(DW), .IDX_W(IW)) bus ();

  regfile_wb_arbiter #(.NUM_REQ(N), .DATA_W(DW), .IDX_W(IW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_pass   = 0;
  int n_checks = 0;

  wb_req_t        m_slot [N]  = '{default: '0};
  int             m_ptr       = 0;
  logic [DW-1:0]  m_rf   [32] = '{default: '0};
  logic [DW-1:0]  dut_rf [32] = '{default: '0};

  logic [EW-1:0] obs;
  assign obs = {bus.wra_en, bus.wra_idx, bus.wra_data,
                bus.wrb_en, bus.wrb_idx, bus.wrb_data,
                bus.req_ready, bus.pending_cnt};

  always @(posedge clk) begin
    if (bus.wra_en) dut_rf[bus.wra_idx] <= bus.wra_data;
    if (bus.wrb_en) dut_rf[bus.wrb_idx] <= bus.wrb_data;
  end

  // Reference: walk requesters in circular order from the pointer.
  function automatic void pick(output int ga, output int gb);
    ga = -1;
    gb = -1;
    for (int k = 0; k < N; k++) begin
      int r;
      r = (m_ptr + k) % N;
      if (m_slot[r].valid && m_slot[r].idx != 0) begin
        if (ga < 0) ga = r;
        else if (gb < 0 && m_slot[r].idx != m_slot[ga].idx) gb = r;
      end
    end
  endfunction

  function automatic logic [EW-1:0] expect_out();
    int ga, gb, cnt;
    logic [N-1:0] rdy;
    logic [IW+DW:0] wa, wb;
    ga = -1; gb = -1; cnt = 0; wa = '0; wb = '0;
    if (!reset) pick(ga, gb);
    if (ga >= 0) wa = {1'b1, m_slot[ga].idx, m_slot[ga].data};
    if (gb >= 0) wb = {1'b1, m_slot[gb].idx, m_slot[gb].data};
    for (int r = 0; r < N; r++) begin
      rdy[r] = !reset && !m_slot[r].valid;
      if (m_slot[r].valid) cnt++;
    end
    return {wa, wb, rdy, CW'(cnt)};
  endfunction

  function automatic void model_edge();
    int ga, gb;
    logic [N-1:0] was;
    if (reset) begin
      for (int r = 0; r < N; r++) m_slot[r].valid = 1'b0;
      m_ptr = 0;
      return;
    end
    pick(ga, gb);
    for (int r = 0; r < N; r++) was[r] = m_slot[r].valid;
    if (ga >= 0) begin m_rf[m_slot[ga].idx] = m_slot[ga].data; m_slot[ga].valid = 1'b0; end
    if (gb >= 0) begin m_rf[m_slot[gb].idx] = m_slot[gb].data; m_slot[gb].valid = 1'b0; end
    for (int r = 0; r < N; r++)
      if (m_slot[r].valid && m_slot[r].idx == 0) m_slot[r].valid = 1'b0;
    if (ga >= 0) m_ptr = (((gb >= 0) ? gb : ga) + 1) % N;
    for (int r = 0; r < N; r++)
      if (bus.req_valid[r] && !was[r])
        m_slot[r] = '{valid: 1'b1, idx: bus.req_idx[r], data: bus.req_data[r]};
  endfunction

  task automatic set_in(input bit rst, input logic [N-1:0] v,
                        input logic [N-1:0][IW-1:0] ix, input logic [N-1:0][DW-1:0] dt);
    reset         = rst;
    bus.req_valid = v;
    bus.req_idx   = ix;
    bus.req_data  = dt;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    set_in(1'b0, '0, '0, '0);
  endtask

  task automatic reset_cycle();
    set_in(1'b1, '0, '0, '0);
    tick();
  endtask

  task automatic test_reset();
    logic [N-1:0][IW-1:0] ix;
    logic [N-1:0][DW-1:0] dt;
    for (int r = 0; r < N; r++) begin ix[r] = IW'(r + 1); dt[r] = $urandom; end
    set_in(1'b1, 4'b1111, ix, dt);
    for (int c = 0; c < 2; c++) begin
      tick();
      n_checks++;
      if ({bus.req_ready, bus.wra_en, bus.wrb_en, bus.pending_cnt} !== '0)
        $display("FAIL reset_hold[%0d]: got ready=%b wra_en=%b wrb_en=%b cnt=%0d, want all 0",
                 c, bus.req_ready, bus.wra_en, bus.wrb_en, bus.pending_cnt);
      else n_pass++;
    end
    idle();
    n_checks++;
    if (bus.req_ready !== 4'b1111)
      $display("FAIL reset_release: got ready=%b want 1111", bus.req_ready);
    else n_pass++;
  endtask

  task automatic test_single_write();
    logic [N-1:0][IW-1:0] ix = '0;
    logic [N-1:0][DW-1:0] dt = '0;
    ix[0] = 5; dt[0] = 32'hDEAD;
    set_in(1'b0, 4'b0001, ix, dt);
    tick();
    idle();
    n_checks++;
    if ({bus.wra_en, bus.wra_idx, bus.wra_data, bus.wrb_en} !== {1'b1, 5'd5, 32'hDEAD, 1'b0})
      $display("FAIL single_port: got en=%b idx=%0d data=%h wrb_en=%b, want 1/5/dead/0",
               bus.wra_en, bus.wra_idx, bus.wra_data, bus.wrb_en);
    else n_pass++;
    tick();
    n_checks++;
    if (obs !== expect_out() || bus.pending_cnt !== 0)
      $display("FAIL single_after: got %h want %h", obs, expect_out());
    else n_pass++;
  endtask

  task automatic test_full_contention();
    logic [N-1:0][IW-1:0] ix;
    logic [N-1:0][DW-1:0] dt;
    reset_cycle();
    for (int r = 0; r < N; r++) begin ix[r] = IW'(r + 1); dt[r] = DW'((r + 1) * 32'h11); end
    set_in(1'b0, 4'b1111, ix, dt);
    tick();
    idle();
    n_checks++;
    if ({bus.wra_idx, bus.wra_data, bus.wrb_idx, bus.wrb_data, bus.wra_en, bus.wrb_en}
        !== {5'd1, 32'h11, 5'd2, 32'h22, 2'b11})
      $display("FAIL contention_c1: got A=%0d/%h B=%0d/%h", bus.wra_idx, bus.wra_data, bus.wrb_idx, bus.wrb_data);
    else n_pass++;
    tick();
    n_checks++;
    if ({bus.wra_idx, bus.wra_data, bus.wrb_idx, bus.wrb_data, bus.wra_en, bus.wrb_en}
        !== {5'd3, 32'h33, 5'd4, 32'h44, 2'b11})
      $display("FAIL contention_c2: got A=%0d/%h B=%0d/%h", bus.wra_idx, bus.wra_data, bus.wrb_idx, bus.wrb_data);
    else n_pass++;
    tick();
    n_checks++;
    if ({dut_rf[1], dut_rf[2], dut_rf[3], dut_rf[4]} !== {32'h11, 32'h22, 32'h33, 32'h44})
      $display("FAIL contention_rf: got %h %h %h %h want 11 22 33 44",
               dut_rf[1], dut_rf[2], dut_rf[3], dut_rf[4]);
    else n_pass++;
  endtask

  task automatic test_zero_reg();
    logic [N-1:0][IW-1:0] ix = '0;
    logic [N-1:0][DW-1:0] dt = '0;
    reset_cycle();
    ix[1] = 0; ix[2] = 7; dt[1] = $urandom; dt[2] = $urandom;
    set_in(1'b0, 4'b0110, ix, dt);
    tick();
    idle();
    n_checks++;
    if ({bus.wra_en, bus.wra_idx, bus.wra_data, bus.wrb_en, bus.req_ready, bus.pending_cnt}
        !== {1'b1, 5'd7, dt[2], 1'b0, 4'b1001, 3'd2})
      $display("FAIL zero_grant: got en=%b idx=%0d wrb_en=%b ready=%b cnt=%0d, want 1/7/0/1001/2",
               bus.wra_en, bus.wra_idx, bus.wrb_en, bus.req_ready, bus.pending_cnt);
    else n_pass++;
    tick();
    n_checks++;
    if ({bus.req_ready, bus.pending_cnt, bus.wra_en} !== {4'b1111, 3'd0, 1'b0})
      $display("FAIL zero_retire: got ready=%b cnt=%0d en=%b, want 1111/0/0",
               bus.req_ready, bus.pending_cnt, bus.wra_en);
    else n_pass++;
  endtask

  task automatic test_same_idx();
    logic [N-1:0][IW-1:0] ix = '0;
    logic [N-1:0][DW-1:0] dt = '0;
    reset_cycle();
    ix[0] = 9; ix[3] = 9; dt[0] = 32'hA; dt[3] = 32'hB;
    set_in(1'b0, 4'b1001, ix, dt);
    tick();
    idle();
    n_checks++;
    if ({bus.wra_en, bus.wra_idx, bus.wra_data, bus.wrb_en} !== {1'b1, 5'd9, 32'hA, 1'b0})
      $display("FAIL same_idx_c1: got en=%b idx=%0d data=%h wrb_en=%b, want 1/9/a/0",
               bus.wra_en, bus.wra_idx, bus.wra_data, bus.wrb_en);
    else n_pass++;
    tick();
    n_checks++;
    if ({bus.wra_en, bus.wra_idx, bus.wra_data, bus.wrb_en} !== {1'b1, 5'd9, 32'hB, 1'b0})
      $display("FAIL same_idx_c2: got en=%b idx=%0d data=%h wrb_en=%b, want 1/9/b/0",
               bus.wra_en, bus.wra_idx, bus.wra_data, bus.wrb_en);
    else n_pass++;
    tick();
    n_checks++;
    if (dut_rf[9] !== 32'hB)
      $display("FAIL same_idx_rf: got x9=%h want b", dut_rf[9]);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [N-1:0][IW-1:0] ix = '0;
    logic [N-1:0][DW-1:0] dt = '0;
    int diffs = 0;
    reset_cycle();
    for (int r = 0; r < 3; r++) begin ix[r] = IW'(12 + r); dt[r] = $urandom; end
    set_in(1'b0, 4'b0111, ix, dt);
    tick();
    set_in(1'b1, '0, '0, '0);
    n_checks++;
    if ({bus.wra_en, bus.wrb_en, bus.req_ready} !== '0)
      $display("FAIL reset_mid_during: got wra_en=%b wrb_en=%b ready=%b, want 0/0/0000",
               bus.wra_en, bus.wrb_en, bus.req_ready);
    else n_pass++;
    tick();
    idle();
    n_checks++;
    if ({bus.pending_cnt, bus.wra_en, bus.wrb_en} !== '0)
      $display("FAIL reset_mid_after: got cnt=%0d wra_en=%b wrb_en=%b, want 0/0/0",
               bus.pending_cnt, bus.wra_en, bus.wrb_en);
    else n_pass++;
    repeat (3) tick();
    for (int i = 0; i < 32; i++) if (dut_rf[i] !== m_rf[i]) diffs++;
    n_checks++;
    if (diffs != 0)
      $display("FAIL reset_mid_rf: got %0d differing registers want 0", diffs);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [N-1:0][IW-1:0] ix;
    logic [N-1:0][DW-1:0] dt;
    logic [N-1:0]         v;
    bit                   rst;
    int                   errs = 0;
    reset_cycle();
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(59) == 0);
      v   = N'($urandom);
      for (int r = 0; r < N; r++) begin ix[r] = IW'($urandom_range(7)); dt[r] = $urandom; end
      set_in(rst, v, ix, dt);
      n_checks++;
      if (obs !== expect_out()) begin
        errs++;
        if (errs <= 10) $display("FAIL random_out[%0d]: got %h want %h", c, obs, expect_out());
      end else n_pass++;
      tick();
    end
    idle();
    repeat (8) tick();
    for (int i = 0; i < 32; i++) begin
      n_checks++;
      if (dut_rf[i] !== m_rf[i])
        $display("FAIL random_rf[x%0d]: got %h want %h", i, dut_rf[i], m_rf[i]);
      else n_pass++;
    end
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_idx   = '0;
    bus.req_data  = '0;
    test_reset();
    test_single_write();
    test_full_contention();
    test_zero_reg();
    test_same_idx();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
